// File: rtl/ccd_bank_scheduler_if.sv
// rtl/ccd_bank_scheduler_if.sv - bank request pool / command bus bundle for ccd_bank_scheduler
interface ccd_bank_scheduler_if #(
  parameter int REQ_SIZE = 32
);
  logic [15:0]            Req;
  logic [15:0]            Valid;
  logic [16*REQ_SIZE-1:0] Data_in;
  logic                   out_ready;
  logic [REQ_SIZE-1:0]    Data_out;
  logic                   wr_en;
  logic [15:0]            Ack;
  logic [3:0]             grant_idx;

  modport master (
    output Req, Valid, Data_in, out_ready,
    input  Data_out, wr_en, Ack, grant_idx
  );

  modport slave (
    input  Req, Valid, Data_in, out_ready,
    output Data_out, wr_en, Ack, grant_idx
  );
endinterface

// File: rtl/ccd_bank_scheduler.sv
// rtl/ccd_bank_scheduler.sv - tCCD-aware two-level round-robin bank grant scheduler
// Optional starvation override enabled by defining CCD_STARV_GUARD_EN.
module ccd_bank_scheduler #(
  parameter int REQ_SIZE = 32,
  parameter int TCCD_S   = 4,
  parameter int TCCD_L   = 8,
  parameter int AGE_MAX  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  ccd_bank_scheduler_if.slave bus
);
  localparam logic [3:0] TCCD_S_C = 4'(TCCD_S);
  localparam logic [3:0] TCCD_L_C = 4'(TCCD_L);

  logic [1:0]          gp_q;
  logic [1:0]          bp_q [4];
  logic [3:0]          ccd_cnt_q, ccd_cnt_d;
  logic [1:0]          last_grp_q;
  logic                last_grp_vld_q;
  logic [REQ_SIZE-1:0] data_out_q;
  logic                wr_en_q;
  logic [15:0]         ack_q;
  logic [3:0]          grant_idx_q;

  logic [15:0] req_vld;
  logic [15:0] elig;
  logic        rr_found;
  logic [3:0]  rr_sel;
  logic [1:0]  g_scan, b_scan;
  logic        pick_found;
  logic [3:0]  pick;
  logic        grant;

  assign req_vld = bus.Req & bus.Valid;

  always_comb begin
    elig = '0;
    for (int i = 0; i < 16; i++) begin
      elig[i] = req_vld[i] & (!last_grp_vld_q |
                ((2'(i >> 2) == last_grp_q) ? (ccd_cnt_q >= TCCD_L_C)
                                            : (ccd_cnt_q >= TCCD_S_C)));
    end
  end

  // Group pointer picks the first group with work, bank pointer of that group picks the slot.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    g_scan   = '0;
    b_scan   = '0;
    for (int gi = 0; gi < 4; gi++) begin
      g_scan = gp_q + 2'(gi);
      for (int bi = 0; bi < 4; bi++) begin
        b_scan = bp_q[g_scan] + 2'(bi);
        if (!rr_found && elig[{g_scan, b_scan}]) begin
          rr_found = 1'b1;
          rr_sel   = {g_scan, b_scan};
        end
      end
    end
  end

`ifdef CCD_STARV_GUARD_EN
  logic [5:0] age_q [16];
  logic       starv_found;
  logic [3:0] starv_sel;

  always_comb begin
    starv_found = 1'b0;
    starv_sel   = '0;
    for (int i = 0; i < 16; i++) begin
      if (!starv_found && elig[i] && (int'(age_q[i]) >= AGE_MAX)) begin
        starv_found = 1'b1;
        starv_sel   = 4'(i);
      end
    end
  end

  assign pick_found = rr_found | starv_found;
  assign pick       = starv_found ? starv_sel : rr_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if ((grant && (pick == 4'(i))) || !bus.Req[i]) begin
          age_q[i] <= '0;
        end else if (req_vld[i] && (age_q[i] != 6'h3F)) begin
          age_q[i] <= age_q[i] + 6'd1;
        end
      end
    end
  end
`else
  assign pick_found = rr_found;
  assign pick       = rr_sel;
`endif

  assign grant     = bus.out_ready & pick_found;
  assign ccd_cnt_d = grant ? 4'd1 :
                     (ccd_cnt_q >= TCCD_L_C) ? ccd_cnt_q : ccd_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gp_q           <= '0;
      for (int g = 0; g < 4; g++) bp_q[g] <= '0;
      ccd_cnt_q      <= TCCD_L_C;
      last_grp_q     <= '0;
      last_grp_vld_q <= 1'b0;
      data_out_q     <= '0;
      wr_en_q        <= 1'b0;
      ack_q          <= '0;
      grant_idx_q    <= '0;
    end else begin
      ccd_cnt_q <= ccd_cnt_d;
      wr_en_q   <= grant;
      ack_q     <= grant ? (16'b1 << pick) : 16'b0;
      if (grant) begin
        data_out_q       <= bus.Data_in[int'(pick)*REQ_SIZE +: REQ_SIZE];
        grant_idx_q      <= pick;
        gp_q             <= pick[3:2] + 2'd1;
        bp_q[pick[3:2]]  <= pick[1:0] + 2'd1;
        last_grp_q       <= pick[3:2];
        last_grp_vld_q   <= 1'b1;
      end
    end
  end

  assign bus.Data_out  = data_out_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.Ack       = ack_q;
  assign bus.grant_idx = grant_idx_q;
endmodule

// File: tb/tb_ccd_bank_scheduler.sv
// tb/tb_ccd_bank_scheduler.sv - scoreboard bench for ccd_bank_scheduler
module tb_ccd_bank_scheduler;
  localparam int REQ_SIZE = 32;
  localparam int TCCD_S   = 4;
  localparam int TCCD_L   = 8;
  localparam int AGE_MAX  = 32;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  int gp_m;
  int bp_m [4];
  int last_t_m, last_g_m;
  bit last_vld_m;
  int age_m [16];

  ccd_bank_scheduler_if #(.REQ_SIZE(REQ_SIZE)) bus ();

  ccd_bank_scheduler #(
    .REQ_SIZE(REQ_SIZE), .TCCD_S(TCCD_S), .TCCD_L(TCCD_L), .AGE_MAX(AGE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    gp_m = 0;
    for (int g = 0; g < 4; g++) bp_m[g] = 0;
    last_t_m = 0; last_g_m = 0; last_vld_m = 0;
    for (int i = 0; i < 16; i++) age_m[i] = 0;
  endtask

  function automatic bit elig_m(int i, logic [15:0] rv);
    int gap;
    gap = ((i / 4) == last_g_m) ? TCCD_L : TCCD_S;
    return rv[i] && (!last_vld_m || (cyc - last_t_m) >= gap);
  endfunction

  // Decide what this cycle's inputs should produce at the next edge.
  task automatic model_decide();
    logic [15:0] rv;
    int win;
    rv  = bus.Req & bus.Valid;
    win = -1;
    if (bus.out_ready) begin
`ifdef CCD_STARV_GUARD_EN
      for (int i = 0; i < 16; i++)
        if (win < 0 && elig_m(i, rv) && age_m[i] >= AGE_MAX) win = i;
`endif
      for (int gi = 0; gi < 4; gi++) begin
        for (int bi = 0; bi < 4; bi++) begin
          int g, b;
          g = (gp_m + gi) % 4;
          b = (bp_m[g] + bi) % 4;
          if (win < 0 && elig_m(g * 4 + b, rv)) win = g * 4 + b;
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (i == win || !bus.Req[i]) age_m[i] = 0;
      else if (rv[i] && age_m[i] < 63) age_m[i]++;
    end
    if (win >= 0) begin
      exp_t e;
      e.idx  = win;
      e.data = bus.Data_in[win*REQ_SIZE +: REQ_SIZE];
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      gp_m            = (win / 4 + 1) % 4;
      bp_m[win / 4]   = (win % 4 + 1) % 4;
      last_t_m        = cyc;
      last_g_m        = win / 4;
      last_vld_m      = 1;
    end
  endtask

  task automatic step(logic [15:0] req, logic [15:0] val, logic rdy);
    bus.Req       = req;
    bus.Valid     = val;
    bus.out_ready = rdy;
    for (int i = 0; i < 16; i++) bus.Data_in[i*REQ_SIZE +: REQ_SIZE] = $urandom;
    model_decide();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", {60'b0, bus.grant_idx}, 64'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("grant_idx", {60'b0, bus.grant_idx}, 64'(e.idx));
          check("data_out", {32'b0, bus.Data_out}, {32'b0, e.data});
          check("ack", {48'b0, bus.Ack}, 64'(16'b1 << e.idx));
          check("grant_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check("ack_idle", {48'b0, bus.Ack}, 64'h0);
      end
    end
  end

  initial begin
    logic [15:0] r;
    bit seen;
    rst_n         = 1'b0;
    bus.Req       = '0;
    bus.Valid     = '0;
    bus.out_ready = 1'b0;
    bus.Data_in   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", {63'b0, bus.wr_en}, 64'h0);
    check("rst_ack", {48'b0, bus.Ack}, 64'h0);
    check("rst_grant_idx", {60'b0, bus.grant_idx}, 64'h0);
    check("rst_data_out", {32'b0, bus.Data_out}, 64'h0);
    rst_n = 1'b1;

    // Single bank held: same-group spacing only.
    repeat (20) step(16'h0001, 16'h0001, 1'b1);
    repeat (10) step(16'h0000, 16'h0000, 1'b1);

    // Two groups, each requester drops on its Ack.
    r = 16'h0011;
    for (int k = 0; k < 14; k++) begin
      step(r, r, 1'b1);
      r = r & ~bus.Ack;
    end

    // All banks with continuous refresh.
    repeat (48) step(16'hFFFF, 16'hFFFF, 1'b1);
    repeat (10) step(16'h0000, 16'h0000, 1'b1);

    // Req without Valid, then valid, then backpressure.
    repeat (3) step(16'h0002, 16'h0000, 1'b1);
    step(16'h0002, 16'h0002, 1'b1);
    r = 16'h0002 & ~bus.Ack;
    repeat (10) step(16'h0000, 16'h0000, 1'b1);
    repeat (3) step(16'h0002, 16'h0002, 1'b0);
    r = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      step(r, r, 1'b1);
      r = r & ~bus.Ack;
    end

    // Reset while a grant is on the bus.
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(16'h0001, 16'h0001, 1'b1);
      seen = bus.wr_en;
    end
    check("wr_en_before_reset", {63'b0, seen}, 64'h1);
    rst_n = 1'b0;
    bus.Req = '0;
    bus.Valid = '0;
    #1;
    check("async_rst_wr_en", {63'b0, bus.wr_en}, 64'h0);
    check("async_rst_ack", {48'b0, bus.Ack}, 64'h0);
    check("async_rst_grant_idx", {60'b0, bus.grant_idx}, 64'h0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      step(r, r, 1'b1);
      r = r & ~bus.Ack;
    end

    // Randomized traffic with random backpressure and sparse/dense mixes.
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] rq, vl;
      rq = 16'($urandom);
      if (k % 1000 < 300) rq = rq & 16'($urandom) & 16'($urandom);
      vl = rq | 16'($urandom);
      if ($urandom_range(0, 7) == 0) vl = 16'($urandom);
      step(rq, vl, ($urandom_range(0, 3) != 0));
    end

    repeat (5) step(16'h0000, 16'h0000, 1'b1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
